// File: rtl/axil_regfile_slave_pkg.sv
// Shared types for the AXI4-Lite register-file slave.
// AXIL_STRB_CHECK_EN (optional) makes partial-strobe writes fail with SLVERR.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam int         REG_IDX_W   = 4;

   typedef enum logic [1:0] {
      W_IDLE,
      W_COMMIT,
      W_RESP
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_FETCH,
      R_RESP
   } rd_state_e;

   // Byte address beyond the register window.
   function automatic logic addr_err(
      input logic [31:0] addr,
      input int          reg_count
   );
      return addr >= 32'(4 * reg_count);
   endfunction

endpackage

// File: rtl/axil_regfile_slave_if.sv
// AXI4-Lite bus bundle between host interconnect and register-file slave.
// AXIL_STRB_CHECK_EN does not change this interface.
interface axil_if #(
   parameter int AXI_ADDR_W = 8
);
   logic [AXI_ADDR_W-1:0] s_awaddr;
   logic                  s_awvalid;
   logic                  s_awready;
   logic [31:0]           s_wdata;
   logic [3:0]            s_wstrb;
   logic                  s_wvalid;
   logic                  s_wready;
   logic [1:0]            s_bresp;
   logic                  s_bvalid;
   logic                  s_bready;
   logic [AXI_ADDR_W-1:0] s_araddr;
   logic                  s_arvalid;
   logic                  s_arready;
   logic [31:0]           s_rdata;
   logic [1:0]            s_rresp;
   logic                  s_rvalid;
   logic                  s_rready;

   modport master (
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid,
      output s_bready, s_araddr, s_arvalid, s_rready,
      input  s_awready, s_wready, s_bresp, s_bvalid,
      input  s_arready, s_rdata, s_rresp, s_rvalid
   );

   modport slave (
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid,
      input  s_bready, s_araddr, s_arvalid, s_rready,
      output s_awready, s_wready, s_bresp, s_bvalid,
      output s_arready, s_rdata, s_rresp, s_rvalid
   );

endinterface

// File: rtl/axil_regfile_slave_wr_channel.sv
// AW/W capture and write FSM driving the register-file write port.
// With AXIL_STRB_CHECK_EN defined, any wstrb other than 4'hF is rejected.
module axil_wr_channel
   import axil_pkg::*;
#(
   parameter int AXI_ADDR_W = 8,
   parameter int REG_COUNT  = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [AXI_ADDR_W-1:0] awaddr_i,
   input  logic                  awvalid_i,
   output logic                  awready_o,
   input  logic [31:0]           wdata_i,
   input  logic [3:0]            wstrb_i,
   input  logic                  wvalid_i,
   output logic                  wready_o,
   output logic [1:0]            bresp_o,
   output logic                  bvalid_o,
   input  logic                  bready_i,
   output logic [REG_IDX_W-1:0]  write_addr_o,
   output logic [31:0]           write_data_o,
   output logic                  write_en_o
);

   wr_state_e             state_q, state_d;
   logic                  aw_held_q, w_held_q;
   logic [AXI_ADDR_W-1:0] awaddr_q;
   logic [31:0]           wdata_q;
   logic [1:0]            bresp_q;
   logic                  aw_hs, w_hs;
   logic                  aw_have, w_have;
   logic                  err;
   logic                  strb_err;

   assign awready_o = ~reset_i & (state_q == W_IDLE) & ~aw_held_q;
   assign wready_o  = ~reset_i & (state_q == W_IDLE) & ~w_held_q;

   assign aw_hs   = awvalid_i & awready_o;
   assign w_hs    = wvalid_i & wready_o;
   assign aw_have = aw_held_q | aw_hs;
   assign w_have  = w_held_q | w_hs;

`ifdef AXIL_STRB_CHECK_EN
   logic [3:0] wstrb_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wstrb_q <= '0;
      end else if (w_hs) begin
         wstrb_q <= wstrb_i;
      end
   end

   assign strb_err = (wstrb_q != 4'hF);
`else
   logic [3:0] unused_wstrb;

   assign unused_wstrb = wstrb_i;
   assign strb_err     = 1'b0;
`endif

   assign err = addr_err(32'(awaddr_q), REG_COUNT) | strb_err;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         W_IDLE:   if (aw_have && w_have) state_d = W_COMMIT;
         W_COMMIT: state_d = W_RESP;
         W_RESP:   if (bready_i) state_d = W_IDLE;
         default:  state_d = W_IDLE;
      endcase
   end

   // Held flags drop as soon as the pair moves on to commit.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         state_q   <= state_d;
         aw_held_q <= (state_d == W_IDLE) & aw_have;
         w_held_q  <= (state_d == W_IDLE) & w_have;
         if (aw_hs) begin
            awaddr_q <= awaddr_i;
         end
         if (w_hs) begin
            wdata_q <= wdata_i;
         end
         if (state_q == W_COMMIT) begin
            bresp_q <= err ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   assign bvalid_o     = (state_q == W_RESP);
   assign bresp_o      = bresp_q;
   assign write_addr_o = awaddr_q[5:2];
   assign write_data_o = wdata_q;
   assign write_en_o   = (state_q == W_COMMIT) & ~err;

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave front end for the 16 x 32-bit config register file.
// Define AXIL_STRB_CHECK_EN to reject writes whose wstrb is not 4'hF.
module axil_regfile_slave
   import axil_pkg::*;
#(
   parameter int AXI_ADDR_W = 8,
   parameter int REG_COUNT  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   axil_if.slave                s,
   output logic [REG_IDX_W-1:0] write_addr,
   output logic [31:0]          write_data,
   output logic                 write_en,
   output logic [REG_IDX_W-1:0] read_addr,
   input  logic [31:0]          read_data
);

   axil_wr_channel #(
      .AXI_ADDR_W (AXI_ADDR_W),
      .REG_COUNT  (REG_COUNT)
   ) u_wr (
      .clk_i        (clk),
      .reset_i      (reset),
      .awaddr_i     (s.s_awaddr),
      .awvalid_i    (s.s_awvalid),
      .awready_o    (s.s_awready),
      .wdata_i      (s.s_wdata),
      .wstrb_i      (s.s_wstrb),
      .wvalid_i     (s.s_wvalid),
      .wready_o     (s.s_wready),
      .bresp_o      (s.s_bresp),
      .bvalid_o     (s.s_bvalid),
      .bready_i     (s.s_bready),
      .write_addr_o (write_addr),
      .write_data_o (write_data),
      .write_en_o   (write_en)
   );

   rd_state_e             rstate_q, rstate_d;
   logic [AXI_ADDR_W-1:0] araddr_q;
   logic [31:0]           rdata_q;
   logic [1:0]            rresp_q;
   logic                  ar_hs;
   logic                  ar_err;

   assign s.s_arready = ~reset & (rstate_q == R_IDLE);
   assign ar_hs       = s.s_arvalid & s.s_arready;
   assign ar_err      = addr_err(32'(araddr_q), REG_COUNT);

   always_comb begin
      rstate_d = rstate_q;
      unique case (rstate_q)
         R_IDLE:  if (ar_hs) rstate_d = R_FETCH;
         R_FETCH: rstate_d = R_RESP;
         R_RESP:  if (s.s_rready) rstate_d = R_IDLE;
         default: rstate_d = R_IDLE;
      endcase
   end

   // Sampling at the fetch edge returns the pre-write value on a collision.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rstate_q <= R_IDLE;
         araddr_q <= '0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else begin
         rstate_q <= rstate_d;
         if (ar_hs) begin
            araddr_q <= s.s_araddr;
         end
         if (rstate_q == R_FETCH) begin
            rdata_q <= ar_err ? 32'h0 : read_data;
            rresp_q <= ar_err ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   assign read_addr = araddr_q[5:2];
   assign s.s_rvalid = (rstate_q == R_RESP);
   assign s.s_rdata  = rdata_q;
   assign s.s_rresp  = rresp_q;

endmodule

// File: doc/axil_regfile_slave.md
Name: axil_regfile_slave

Overview:
AXI4-Lite slave front end for the 16 x 32-bit configuration register file that supplies res_x, res_y and fps.
- Terminates the AXI-Lite write channels (AW, W, B) and read channels (AR, R) from the host interconnect.
- Drives the register file's write port (write_addr/write_data/write_en) and read port (read_addr/read_data).
- Write and read paths are independent FSMs and may be in flight at the same time.

Parameters:
AXI_ADDR_W, 8, AXI byte-address width; must be >= 6.
REG_COUNT, 16, number of 32-bit registers; byte window is 0 .. 4*REG_COUNT-1.

Ports:
clk  in  1  system clock, all logic rising-edge.
reset  in  1  asynchronous, active-high reset.
s_awaddr  in  AXI_ADDR_W  write address (byte).
s_awvalid  in  1  write address valid.
s_awready  out  1  write address ready.
s_wdata  in  32  write data.
s_wstrb  in  4  write byte strobes.
s_wvalid  in  1  write data valid.
s_wready  out  1  write data ready.
s_bresp  out  2  write response.
s_bvalid  out  1  write response valid.
s_bready  in  1  write response ready.
s_araddr  in  AXI_ADDR_W  read address (byte).
s_arvalid  in  1  read address valid.
s_arready  out  1  read address ready.
s_rdata  out  32  read data.
s_rresp  out  2  read response.
s_rvalid  out  1  read data valid.
s_rready  in  1  read data ready.
write_addr  out  4  register index to register file.
write_data  out  32  register write data.
write_en  out  1  single-cycle register write strobe.
read_addr  out  4  register index to register file.
read_data  in  32  combinational read data from register file.

Behaviour:
- Reset: clk and reset as fixed above. While reset is high all outputs are 0: readies, valids, resp, rdata, write_*, read_addr.
- Address decode:
  - Index = addr[5:2]; addr[1:0] are ignored.
  - addr >= 4*REG_COUNT is a decode error: resp = SLVERR (2'b10), no write, rdata = 0.
  - Otherwise resp = OKAY (2'b00).
- Write FSM, W_IDLE -> W_COMMIT -> W_RESP -> W_IDLE:
  - W_IDLE: s_awready = 1 until AW is captured; s_wready = 1 until W is captured. AW and W are accepted in either order or in the same cycle, and each is held once captured.
  - When both AW and W are held, go to W_COMMIT.
  - W_COMMIT (1 cycle): write_addr/write_data are registered values. write_en = 1 only if there is no error.
  - W_RESP: s_bvalid = 1 and s_bresp stable until s_bready; both handshakes of the next write are blocked until then.
  - Latency: AW and W in the same cycle (edge N) -> write_en in cycle N+1 -> s_bvalid from edge N+2.
  - s_bready held high -> one write per 3 cycles.
- Read FSM, R_IDLE -> R_FETCH -> R_RESP -> R_IDLE:
  - R_IDLE: s_arready = 1; the AR handshake latches the address.
  - R_FETCH (1 cycle): read_addr = latched index. At the edge, s_rdata <= read_data (or 0 on error), and s_rresp is set.
  - R_RESP: s_rvalid = 1 and s_rdata/s_rresp stable until s_rready.
  - Latency: AR at edge N -> s_rvalid from edge N+2.
- Simultaneous events:
  - A read in R_FETCH and write_en to the same index in the same cycle -> the read returns the old value.
  - Read and write FSMs never stall each other.
- Backpressure: s_bvalid/s_rvalid never drop before their ready; payload never changes while valid is high.
- Reset mid-transaction: the transaction is abandoned, write_en is not issued, no response is produced, both FSMs return to idle.

Optional Feature:
AXIL_STRB_CHECK_EN
- Defined: a write with s_wstrb != 4'hF gets SLVERR and no write_en.
- Undefined: s_wstrb is ignored and every in-range write stores all 32 bits.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Write state enum {W_IDLE, W_COMMIT, W_RESP}, read state enum {R_IDLE, R_FETCH, R_RESP}.
  - REG_IDX_W = 4.
- Natural sub-module: axil_wr_channel, which holds the AW/W capture and the write FSM. The read FSM stays in the top.

Test Plan:
- AW 0x04 and W 0x00000780 in the same cycle, bready = 1 -> write_en for one cycle with addr 1, data 0x780 in cycle N+1; bvalid at N+2, bresp 0.
- W 0x12345678 three cycles before AW 0x08 -> single write_en to index 2 after AW; exactly one B response.
- AR 0x04 after the write above -> rvalid 2 cycles later, rdata 0x780, rresp 0. With rready held low 5 cycles -> rdata stable, no new AR accepted.
- AW 0x40 / AR 0x7C -> no write_en; bresp 2'b10; rresp 2'b10 with rdata 0.
- Read and write to index 0 collide: old value 0x0 returned, new value returned on the next read. Check with and without AXIL_STRB_CHECK_EN using wstrb 4'h3: SLVERR with no write when defined, full write when undefined.
- Assert reset while in W_COMMIT/W_RESP -> all outputs 0, no write_en, no bvalid afterwards. A new write after reset completes normally.
